// File: rtl/rf_fault_sequencer.sv
// Supervisory FSM between host commands, the watchdog and the AM carrier amplitude path.
// Build option SEQ_SOFT_RAMP_EN: timed amplitude ramp-down on timeout; otherwise amplitude is cut in one cycle.
module rf_fault_sequencer #(
    parameter int AMP_W     = 16,
    parameter int RAMP_STEP = 256,
    parameter int RAMP_DIV  = 1000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             host_arm,
    input  logic             host_clear,
    input  logic             host_heartbeat,
    input  logic             wd_triggered,
    input  logic             wd_warning,
    input  logic [AMP_W-1:0] amp_in,
    output logic             wd_enable,
    output logic             wd_heartbeat,
    output logic             wd_force_reset,
    output logic [AMP_W-1:0] amp_out,
    output logic             rf_enable,
    output logic             warn_out,
    output logic             fault_latched,
    output logic [7:0]       fault_count,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        RUN  = 3'd2,
        RAMP = 3'd3,
        SAFE = 3'd4
    } state_t;

    state_t cur_st;
    logic   hb_p0;
    logic   hb_edge;

    if (RAMP_DIV < 1 || RAMP_STEP < 1) begin : g_param_check
        $error("rf_fault_sequencer: RAMP_DIV and RAMP_STEP must be at least 1");
    end

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

`ifdef SEQ_SOFT_RAMP_EN
    localparam int               CNT_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(RAMP_DIV - 1);
    localparam logic [AMP_W:0]   STEP_EXT = (AMP_W+1)'(RAMP_STEP);

    logic [CNT_W-1:0] ramp_cnt;

    // One extra bit so a step larger than the remaining amplitude shows up as a negative result.
    function automatic logic [AMP_W-1:0] ramp_dec(input logic [AMP_W-1:0] a);
        logic signed [AMP_W:0] diff;
        diff = $signed({1'b0, a}) - $signed(STEP_EXT);
        return diff[AMP_W] ? '0 : diff[AMP_W-1:0];
    endfunction
`endif

    assign hb_edge = host_heartbeat & ~hb_p0;
    assign state   = cur_st;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_st         <= IDLE;
            hb_p0          <= 1'b0;
            wd_enable      <= 1'b0;
            wd_heartbeat   <= 1'b0;
            wd_force_reset <= 1'b0;
            amp_out        <= '0;
            rf_enable      <= 1'b0;
            warn_out       <= 1'b0;
            fault_latched  <= 1'b0;
            fault_count    <= 8'd0;
`ifdef SEQ_SOFT_RAMP_EN
            ramp_cnt       <= '0;
`endif
        end else begin
            // Edge-detect sample stage; pulse outputs default low every cycle.
            hb_p0          <= host_heartbeat;
            wd_heartbeat   <= 1'b0;
            wd_force_reset <= 1'b0;
            warn_out       <= 1'b0;

            case (cur_st)
                IDLE: begin
                    wd_enable     <= 1'b0;
                    rf_enable     <= 1'b0;
                    amp_out       <= '0;
                    fault_latched <= 1'b0;
                    if (host_arm) begin
                        cur_st         <= ARM;
                        wd_force_reset <= 1'b1;
                        wd_enable      <= 1'b1;
                    end
                end

                ARM: begin
                    cur_st    <= RUN;
                    wd_enable <= 1'b1;
                    rf_enable <= 1'b1;
                    warn_out  <= wd_warning;
                end

                RUN: begin
                    if (wd_triggered) begin
                        cur_st      <= RAMP;
                        fault_count <= sat_inc8(fault_count);
`ifdef SEQ_SOFT_RAMP_EN
                        amp_out     <= amp_in;
                        ramp_cnt    <= '0;
`else
                        amp_out     <= '0;
`endif
                    end else if (!host_arm) begin
                        cur_st    <= IDLE;
                        wd_enable <= 1'b0;
                        rf_enable <= 1'b0;
                        amp_out   <= '0;
                    end else begin
                        amp_out      <= amp_in;
                        wd_heartbeat <= hb_edge;
                        warn_out     <= wd_warning;
                    end
                end

                RAMP: begin
`ifdef SEQ_SOFT_RAMP_EN
                    if (amp_out == '0) begin
                        cur_st        <= SAFE;
                        wd_enable     <= 1'b0;
                        rf_enable     <= 1'b0;
                        fault_latched <= 1'b1;
                    end else if (ramp_cnt == DIV_LAST) begin
                        amp_out  <= ramp_dec(amp_out);
                        ramp_cnt <= '0;
                    end else begin
                        ramp_cnt <= ramp_cnt + CNT_W'(1);
                    end
`else
                    cur_st        <= SAFE;
                    wd_enable     <= 1'b0;
                    rf_enable     <= 1'b0;
                    amp_out       <= '0;
                    fault_latched <= 1'b1;
`endif
                end

                SAFE: begin
                    wd_enable <= 1'b0;
                    rf_enable <= 1'b0;
                    amp_out   <= '0;
                    // RF stays off until the operator acknowledges; host_arm picks re-arm or idle.
                    if (host_clear) begin
                        fault_latched <= 1'b0;
                        if (host_arm) begin
                            cur_st         <= ARM;
                            wd_force_reset <= 1'b1;
                            wd_enable      <= 1'b1;
                        end else begin
                            cur_st <= IDLE;
                        end
                    end
                end

                default: begin
                    cur_st        <= IDLE;
                    wd_enable     <= 1'b0;
                    rf_enable     <= 1'b0;
                    amp_out       <= '0;
                    fault_latched <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rf_fault_sequencer.md
# rf_fault_sequencer

Supervisory controller that sits between the host command path, the watchdog timer and the AM carrier amplitude datapath. It arms and disarms the watchdog and forwards host heartbeats to it as clean single-cycle pulses. On watchdog timeout it ramps the carrier amplitude down to zero, latches the fault and holds RF off until the operator explicitly clears it.

## Interface
Parameters:
- AMP_W, 16, width of amplitude words
- RAMP_STEP, 256, amplitude decrement per ramp tick
- RAMP_DIV, 1000, clock cycles per ramp tick (≥1)

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- host_arm  in  1  level; 1 = operator requests transmit with watchdog supervision
- host_clear  in  1  single-cycle pulse; acknowledges a latched fault
- host_heartbeat  in  1  level toggling from command interface; each rising edge is one heartbeat
- wd_triggered  in  1  watchdog timeout flag
- wd_warning  in  1  watchdog early-warning flag
- amp_in  in  AMP_W  requested carrier amplitude
- wd_enable  out  1  watchdog enable
- wd_heartbeat  out  1  single-cycle heartbeat pulse to watchdog
- wd_force_reset  out  1  single-cycle watchdog counter clear
- amp_out  out  AMP_W  amplitude to modulator
- rf_enable  out  1  RF output stage enable
- warn_out  out  1  registered copy of wd_warning, valid in RUN only, else 0
- fault_latched  out  1  timeout fault pending operator clear
- fault_count  out  8  timeouts since reset, saturates at 255
- state  out  3  current state encoding

## Operation
- States: IDLE=0, ARM=1, RUN=2, RAMP=3, SAFE=4. Encodings 5–7 are unreachable and return to IDLE.
- IDLE: wd_enable=0, rf_enable=0, amp_out=0. host_arm=1 → ARM.
- ARM (exactly one cycle): wd_force_reset=1, wd_enable=1, heartbeat not forwarded → RUN.
- RUN: wd_enable=1, rf_enable=1, amp_out←amp_in each cycle. Heartbeat edges forwarded.
  - wd_triggered=1 → RAMP; fault_count+1 (saturating).
  - Else host_arm=0 → IDLE; amp_out←0 next cycle, no fault.
- RAMP: wd_enable stays 1, rf_enable stays 1, heartbeats dropped, host_arm ignored.
  - Every RAMP_DIV cycles, amp_out←max(amp_out−RAMP_STEP, 0). The subtraction is done in AMP_W+1 bits, and an underflow clamps to 0.
  - amp_out==0 → SAFE (this includes entering RAMP with amp_out already 0).
- SAFE: rf_enable=0, amp_out=0, wd_enable=0, fault_latched=1.
  - host_clear with host_arm=1 → ARM, and fault_latched clears.
  - host_clear with host_arm=0 → IDLE, and fault_latched clears.
  - Without host_clear, SAFE is held indefinitely.
- Heartbeat edge detect: a register samples host_heartbeat. An edge is host_heartbeat=1 while the registered sample is 0.
  - wd_heartbeat is never high on two consecutive cycles.
  - wd_heartbeat is never high together with wd_force_reset.
- Priorities within one cycle:
  - reset > wd_triggered > host_arm deassert > heartbeat.
  - In RUN, an edge coinciding with wd_triggered is dropped.

## Timing
- Reset: asynchronous. Every output is 0 and state is IDLE while rstn=0 and on the first edge after release.
- All outputs are registered. State transitions take effect on the cycle after the causing input is sampled.
- host_arm rising at edge N: ARM at N+1, RUN at N+2. amp_out first equals amp_in at N+3.
- Heartbeat latency: host_heartbeat rise sampled at edge N gives wd_heartbeat=1 for the cycle after N.
- Ramp duration from A to 0: ceil(A/RAMP_STEP) ticks of RAMP_DIV cycles, plus one cycle into SAFE.
- Reset mid-RAMP or mid-SAFE: immediate return to IDLE. fault_latched and fault_count clear.

## Configuration
- SEQ_SOFT_RAMP_EN defined: RAMP behaves as described above.
- SEQ_SOFT_RAMP_EN undefined: the ramp counter and subtractor are not built.
  - RAMP lasts one cycle with amp_out forced to 0, then SAFE.
  - Total trigger-to-SAFE time is 2 cycles.

## Test plan
- Reset with all inputs 0, then host_arm=1 → state 0→1→2; wd_force_reset high exactly one cycle; rf_enable=1 from RUN.
- RUN with amp_in=0x1234, host_heartbeat toggling every 10 cycles → amp_out=0x1234; one wd_heartbeat pulse per rising edge, never consecutive; wd_triggered stays 0.
- RUN with amp_in=0x0300, RAMP_STEP=256, RAMP_DIV=4, then wd_triggered=1 → amp_out 0x0300→0x0200→0x0100→0x0000, 4 cycles per step; SAFE; fault_latched=1; fault_count=1; rf_enable=0.
- SAFE with host_clear while host_arm=1 → ARM then RUN; fault_latched=0. Same case with host_arm=0 → IDLE.
- In RUN, host_arm falls in the same cycle wd_triggered rises → RAMP is entered (not IDLE); fault_count increments; a coincident heartbeat edge is not forwarded.
- Assert rstn=0 mid-RAMP → all outputs 0 immediately; state IDLE; fault_count=0. With SEQ_SOFT_RAMP_EN undefined, a trigger reaches SAFE in 2 cycles.
